// File: rtl/micro_sequencer.sv
// Micro-sequencer: one-hot timing ring plus fetch/execute bus strobes for the IR/A/B/ALU datapath.
// Optional MICRO_SEQUENCER_SINGLE_STEP_EN adds step_req for one-instruction stepping while paused.
module micro_sequencer #(
  parameter int              OP_W    = 4,
  parameter int              MAX_T   = 6,
  parameter logic [OP_W-1:0] HALT_OP = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
`ifdef MICRO_SEQUENCER_SINGLE_STEP_EN
  input  logic             step_req,
`endif
  input  logic [OP_W-1:0]  instr,
  output logic [MAX_T-1:0] T,
  output logic             pc_out,
  output logic             mar_in,
  output logic             ram_out,
  output logic             ir_in,
  output logic             pc_inc,
  output logic             a_in,
  output logic             a_out,
  output logic             b_in,
  output logic             b_out,
  output logic             alu_in,
  output logic             alu_out,
  output logic             instr_done,
  output logic             halted,
  output logic             illegal
);
  localparam int SW = $clog2(MAX_T);

  typedef enum logic [1:0] {IDLE, EXEC, HALTED} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] step, step_nxt;
  logic          go, halt_hit;

`ifdef MICRO_SEQUENCER_SINGLE_STEP_EN
  assign go = run | step_req;
`else
  assign go = run;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    T          = '0;
    pc_out     = 1'b0;
    mar_in     = 1'b0;
    ram_out    = 1'b0;
    ir_in      = 1'b0;
    pc_inc     = 1'b0;
    a_in       = 1'b0;
    a_out      = 1'b0;
    b_in       = 1'b0;
    b_out      = 1'b0;
    alu_in     = 1'b0;
    alu_out    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    halt_hit   = 1'b0;
    unique case (state)
      IDLE: begin
        step_nxt = '0;
        if (go) state_nxt = EXEC;
      end
      EXEC: begin
        T = MAX_T'(1) << step;
        if (step == SW'(0)) begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end else if (step == SW'(1)) begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end else if (step == SW'(2)) begin
          if (instr == HALT_OP) begin
            instr_done = 1'b1;
            halt_hit   = 1'b1;
          end else begin
            case (instr)
              OP_W'(0): begin b_out = 1'b1; alu_in = 1'b1; end
              OP_W'(1): begin a_out = 1'b1; b_in = 1'b1; instr_done = 1'b1; end
              OP_W'(2): begin b_out = 1'b1; a_in = 1'b1; instr_done = 1'b1; end
              OP_W'(3): begin a_out = 1'b1; alu_in = 1'b1; end
              default:  begin illegal = 1'b1; instr_done = 1'b1; end
            endcase
          end
        end else if (step == SW'(3)) begin
          case (instr)
            OP_W'(0): begin alu_out = 1'b1; b_in = 1'b1; end
            OP_W'(3): begin alu_out = 1'b1; a_in = 1'b1; end
            default:  ;
          endcase
          instr_done = 1'b1;
        end else begin
          instr_done = 1'b1;
        end
        // Never let the ring run past the last timing state.
        if (step == SW'(MAX_T - 1)) instr_done = 1'b1;
        step_nxt = instr_done ? '0 : step + SW'(1);
        // Halt wins over a simultaneous pause.
        if (halt_hit)                 state_nxt = HALTED;
        else if (instr_done && !run)  state_nxt = IDLE;
      end
      HALTED: begin
        halted   = 1'b1;
        step_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// Table-driven bench for micro_sequencer: per-cycle vectors, expectations queued and checked on the falling edge.
module tb_micro_sequencer;
  localparam int OP_W  = 4;
  localparam int MAX_T = 6;

  localparam logic [13:0] PCO = 14'h1 << 13, MARI = 14'h1 << 12, RAMO = 14'h1 << 11,
                          IRI = 14'h1 << 10, PCI  = 14'h1 << 9,  AI   = 14'h1 << 8,
                          AO  = 14'h1 << 7,  BI   = 14'h1 << 6,  BO   = 14'h1 << 5,
                          ALUI = 14'h1 << 4, ALUO = 14'h1 << 3,  DN   = 14'h1 << 2,
                          HL  = 14'h1 << 1,  IL   = 14'h1;
  localparam logic [13:0] F0 = PCO | MARI;
  localparam logic [13:0] F1 = RAMO | IRI | PCI;

  typedef struct {
    logic             rst;
    logic             run;
    logic             sr;
    logic [OP_W-1:0]  op;
    logic [MAX_T-1:0] t;
    logic [13:0]      sig;
  } vec_t;

  typedef struct {
    int               id;
    logic [MAX_T-1:0] t;
    logic [13:0]      sig;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step_req = 1'b0;
  logic [OP_W-1:0]  instr = '0;
  logic [MAX_T-1:0] T;
  logic pc_out, mar_in, ram_out, ir_in, pc_inc, a_in, a_out, b_in, b_out;
  logic alu_in, alu_out, instr_done, halted, illegal;

  int   total = 0, bad = 0, nvec = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  micro_sequencer #(.OP_W(OP_W), .MAX_T(MAX_T), .HALT_OP(4'hF)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef MICRO_SEQUENCER_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .instr(instr), .T(T),
    .pc_out(pc_out), .mar_in(mar_in), .ram_out(ram_out), .ir_in(ir_in), .pc_inc(pc_inc),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .b_out(b_out), .alu_in(alu_in), .alu_out(alu_out),
    .instr_done(instr_done), .halted(halted), .illegal(illegal)
  );

  wire [13:0] sig = {pc_out, mar_in, ram_out, ir_in, pc_inc, a_in, a_out, b_in, b_out,
                     alu_in, alu_out, instr_done, halted, illegal};

  function automatic vec_t v(logic rst, logic rn, logic sr, logic [OP_W-1:0] op,
                             logic [MAX_T-1:0] t, logic [13:0] s);
    vec_t x;
    x.rst = rst; x.run = rn; x.sr = sr; x.op = op; x.t = t; x.sig = s;
    return x;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue what that cycle must show.
  task automatic apply(input vec_t x);
    exp_t e;
    @(posedge clk);
    #1;
    reset = x.rst; run = x.run; step_req = x.sr; instr = x.op;
    e.id = nvec; e.t = x.t; e.sig = x.sig;
    sb.push_back(e);
    nvec++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (T !== e.t || sig !== e.sig) begin
        bad++;
        $display("FAIL vec%0d: T got %b want %b, strobes got %b want %b", e.id, T, e.t, sig, e.sig);
      end
    end
  end

  // Single bus driver.
  always @(negedge clk) begin
    if (!reset)
      assert ($countones({pc_out, ram_out, a_out, b_out, alu_out}) <= 1)
      else begin
        bad++;
        $display("FAIL bus_excl: out strobes %b", {pc_out, ram_out, a_out, b_out, alu_out});
      end
  end

  initial begin
    // Reset state, then IncB, MovAB, MovBA, IncA back to back.
    vecs.push_back(v(1,0,0,0, 0, 0));
    vecs.push_back(v(0,1,0,0, 0, 0));
    vecs.push_back(v(0,1,0,0, 6'b000001, F0));
    vecs.push_back(v(0,1,0,0, 6'b000010, F1));
    vecs.push_back(v(0,1,0,0, 6'b000100, BO | ALUI));
    vecs.push_back(v(0,1,0,0, 6'b001000, ALUO | BI | DN));
    vecs.push_back(v(0,1,0,1, 6'b000001, F0));
    vecs.push_back(v(0,1,0,1, 6'b000010, F1));
    vecs.push_back(v(0,1,0,1, 6'b000100, AO | BI | DN));
    vecs.push_back(v(0,1,0,2, 6'b000001, F0));
    vecs.push_back(v(0,1,0,2, 6'b000010, F1));
    vecs.push_back(v(0,1,0,2, 6'b000100, BO | AI | DN));
    vecs.push_back(v(0,1,0,3, 6'b000001, F0));
    vecs.push_back(v(0,1,0,3, 6'b000010, F1));
    vecs.push_back(v(0,1,0,3, 6'b000100, AO | ALUI));
    vecs.push_back(v(0,1,0,3, 6'b001000, ALUO | AI | DN));
    // Illegal opcode acts as a NOP and fetch continues.
    vecs.push_back(v(0,1,0,7, 6'b000001, F0));
    vecs.push_back(v(0,1,0,7, 6'b000010, F1));
    vecs.push_back(v(0,1,0,7, 6'b000100, DN | IL));
    vecs.push_back(v(0,1,0,1, 6'b000001, F0));
    vecs.push_back(v(0,1,0,1, 6'b000010, F1));
    vecs.push_back(v(0,0,0,1, 6'b000100, AO | BI | DN));
    vecs.push_back(v(0,0,0,3, 0, 0));
    // Run dropped mid-IncA: T3 still completes, then idle, then restart.
    vecs.push_back(v(0,1,0,3, 0, 0));
    vecs.push_back(v(0,1,0,3, 6'b000001, F0));
    vecs.push_back(v(0,1,0,3, 6'b000010, F1));
    vecs.push_back(v(0,0,0,3, 6'b000100, AO | ALUI));
    vecs.push_back(v(0,0,0,3, 6'b001000, ALUO | AI | DN));
    vecs.push_back(v(0,0,0,3, 0, 0));
    vecs.push_back(v(0,1,0,0, 0, 0));
    vecs.push_back(v(0,1,0,0, 6'b000001, F0));
    vecs.push_back(v(0,1,0,0, 6'b000010, F1));
    vecs.push_back(v(0,1,0,0, 6'b000100, BO | ALUI));
    // Reset during T3 of IncB aborts; nothing follows.
    vecs.push_back(v(1,1,0,0, 6'b001000, ALUO | BI | DN));
    vecs.push_back(v(0,0,0,0, 0, 0));
    vecs.push_back(v(0,0,0,0, 0, 0));
`ifdef MICRO_SEQUENCER_SINGLE_STEP_EN
    vecs.push_back(v(0,0,1,1, 0, 0));
    vecs.push_back(v(0,0,0,1, 6'b000001, F0));
    vecs.push_back(v(0,0,1,1, 6'b000010, F1));
    vecs.push_back(v(0,0,0,1, 6'b000100, AO | BI | DN));
    vecs.push_back(v(0,0,0,1, 0, 0));
    vecs.push_back(v(0,0,0,1, 0, 0));
`endif
    // Halt coinciding with run=0 still halts.
    vecs.push_back(v(0,1,0,15, 0, 0));
    vecs.push_back(v(0,1,0,15, 6'b000001, F0));
    vecs.push_back(v(0,1,0,15, 6'b000010, F1));
    vecs.push_back(v(0,0,0,15, 6'b000100, DN));
    vecs.push_back(v(0,0,0,15, 0, HL));

    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    foreach (vecs[i]) apply(vecs[i]);

    // Halted holds for 20 cycles of run=1, even with a step request.
    for (int i = 0; i < 20; i++) apply(v(0, 1, (i == 5), 4'(i), 0, HL));
    // Reset is the only exit.
    apply(v(1,1,0,0, 0, HL));
    apply(v(0,0,0,0, 0, 0));
    apply(v(0,1,0,0, 0, 0));
    apply(v(0,1,0,0, 6'b000001, F0));

    fork
      begin : drain
        while (sb.size() > 0) @(posedge clk);
        @(posedge clk);
      end
      begin : guard
        repeat (20) @(posedge clk);
        if (sb.size() > 0) begin
          bad++;
          $display("FAIL drain: %0d checks pending want 0", sb.size());
        end
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
